// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank
//
// Multi-channel I/O port block used by the memory stage of the five-stage
// pipeline. Each of NPORTS input channels is buffered by a DEPTH-entry FIFO
// filled by the outside world; the pipeline pops one channel at a time with
// an IN instruction (IOE & IOR). NPORTS registered output ports are loaded by
// OUT instructions (IOE & IOW) and pulse a one-cycle strobe when written.
//
// Optional feature macro: IO_IRQ_EN
//   defined   -> adds output IRQ, high while any input FIFO holds data
//   undefined -> no IRQ port, no IRQ logic
//
// Parameters
//   WIDTH   data width of every port, Result and IN
//   NPORTS  number of input channels and of output channels (>= 1)
//   DEPTH   entries per input FIFO (power of two, >= 2)
//   SELW    width of PORT_SEL (>= clog2(NPORTS), min 1)
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   IOE           I/O enable from the memory stage
//   IOR           read request: pop the selected input FIFO into IN
//   IOW           write request: load Result into the selected output port
//   PORT_SEL      channel index for IOR/IOW (out-of-range values are ignored)
//   Result        write data for IOW
//   PORTIN        packed external input data, channel k at [k*WIDTH +: WIDTH]
//   PORTIN_VALID  per-channel push strobe
//   PORTIN_FULL   per-channel FIFO full, decoded from the registered occupancy
//   PORTOUT       packed registered output ports
//   PORTOUT_STB   one-cycle pulse on the output channel just written
//   IN            registered read data returned to the pipeline
//   IN_VALID      high for one cycle when IN holds freshly popped data
//   IRQ           (IO_IRQ_EN only) any input FIFO non-empty
// -----------------------------------------------------------------------------
module io_port_bank #(
   parameter int WIDTH  = 16,
   parameter int NPORTS = 4,
   parameter int DEPTH  = 4,
   parameter int SELW   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     IOE,
   input  logic                     IOR,
   input  logic                     IOW,
   input  logic [SELW-1:0]          PORT_SEL,
   input  logic [WIDTH-1:0]         Result,
   input  logic [NPORTS*WIDTH-1:0]  PORTIN,
   input  logic [NPORTS-1:0]        PORTIN_VALID,
   output logic [NPORTS-1:0]        PORTIN_FULL,
   output logic [NPORTS*WIDTH-1:0]  PORTOUT,
   output logic [NPORTS-1:0]        PORTOUT_STB,
   output logic [WIDTH-1:0]         IN,
   output logic                     IN_VALID
`ifdef IO_IRQ_EN
   ,
   output logic                     IRQ
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // pointer width
   localparam int CW = $clog2(DEPTH + 1);                 // occupancy 0..DEPTH

   // NPORTS always fits in SELW+1 bits, so the range test never truncates.
   localparam logic [SELW:0] NPORTS_L = (SELW + 1)'(NPORTS);
   localparam logic [CW-1:0] DEPTH_L  = CW'(DEPTH);

   // Pointer advance; DEPTH is a power of two so the natural PW-bit wrap
   // takes DEPTH-1 back to 0.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p,
                                              input logic          adv);
      ptr_next = p + PW'(adv);
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q   [NPORTS][DEPTH];
   logic [PW-1:0]    wptr_q  [NPORTS];
   logic [PW-1:0]    wptr_d  [NPORTS];
   logic [PW-1:0]    rptr_q  [NPORTS];
   logic [PW-1:0]    rptr_d  [NPORTS];
   logic [CW-1:0]    cnt_q   [NPORTS];
   logic [CW-1:0]    cnt_d   [NPORTS];
   logic [WIDTH-1:0] pout_q  [NPORTS];
   logic [WIDTH-1:0] pout_d  [NPORTS];
   logic [NPORTS-1:0] stb_q, stb_d;
   logic [WIDTH-1:0] in_q, in_d;
   logic             in_vld_q, in_vld_d;
   logic             irq_q, irq_d;

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   logic              sel_ok;
   logic              rd_req;
   logic              wr_req;
   logic [NPORTS-1:0] sel_hit;
   logic [NPORTS-1:0] full;
   logic [NPORTS-1:0] push;
   logic [NPORTS-1:0] pop;
   logic [WIDTH-1:0]  head;

   assign sel_ok = ({1'b0, PORT_SEL} < NPORTS_L);
   assign rd_req = IOE & IOR & sel_ok;
   assign wr_req = IOE & IOW & sel_ok;

   always_comb begin
      sel_hit = '0;
      full    = '0;
      push    = '0;
      pop     = '0;
      head    = '0;
      for (int k = 0; k < NPORTS; k++) begin
         sel_hit[k] = sel_ok && (PORT_SEL == SELW'(k));
         full[k]    = (cnt_q[k] == DEPTH_L);
         // Full is judged on the registered occupancy, so a push into a full
         // FIFO is lost even when the same edge pops that channel.
         push[k]    = PORTIN_VALID[k] & ~full[k];
         // Empty is also judged on the registered occupancy: no bypass of a
         // same-cycle push into an empty FIFO.
         pop[k]     = rd_req & sel_hit[k] & (cnt_q[k] != '0);
         if (sel_hit[k]) begin
            head = mem_q[k][rptr_q[k]];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------
   always_comb begin
      irq_d = 1'b0;
      stb_d = '0;
      for (int k = 0; k < NPORTS; k++) begin
         wptr_d[k] = ptr_next(wptr_q[k], push[k]);
         rptr_d[k] = ptr_next(rptr_q[k], pop[k]);
         cnt_d[k]  = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
         stb_d[k]  = wr_req & sel_hit[k];
         pout_d[k] = stb_d[k] ? Result : pout_q[k];
         if (cnt_d[k] != '0) begin
            irq_d = 1'b1;
         end
      end
      in_vld_d = |pop;
      in_d     = (|pop) ? head : in_q;
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NPORTS; k++) begin
            wptr_q[k] <= '0;
            rptr_q[k] <= '0;
            cnt_q[k]  <= '0;
            pout_q[k] <= '0;
         end
         stb_q    <= '0;
         in_q     <= '0;
         in_vld_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         for (int k = 0; k < NPORTS; k++) begin
            wptr_q[k] <= wptr_d[k];
            rptr_q[k] <= rptr_d[k];
            cnt_q[k]  <= cnt_d[k];
            pout_q[k] <= pout_d[k];
         end
         stb_q    <= stb_d;
         in_q     <= in_d;
         in_vld_q <= in_vld_d;
         irq_q    <= irq_d;
      end
   end

   // FIFO storage carries no reset; stale entries are unreachable once the
   // pointers and occupancy are cleared.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NPORTS; k++) begin
         if (!reset && push[k]) begin
            mem_q[k][wptr_q[k]] <= PORTIN[k*WIDTH +: WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < NPORTS; g++) begin : g_out
      assign PORTOUT[g*WIDTH +: WIDTH] = pout_q[g];
   end

   assign PORTIN_FULL = full;
   assign PORTOUT_STB = stb_q;
   assign IN          = in_q;
   assign IN_VALID    = in_vld_q;

`ifdef IO_IRQ_EN
   assign IRQ = irq_q;
`else
   // Without the IRQ port the flag register has no reader; keep it referenced
   // so the default build stays free of unused-signal noise.
   logic irq_unused;
   assign irq_unused = irq_q;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// -----------------------------------------------------------------------------
// tb_io_port_bank
//
// Directed bench for io_port_bank (WIDTH=16, NPORTS=4, DEPTH=4, SELW=3).
// Stimulus tasks push expected read data and expected write strobes into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// shows IN_VALID or a PORTOUT_STB pulse. Cycles that must produce nothing are
// checked directly after the edge. Build with +define+IO_IRQ_EN to add the
// IRQ sequence.
// -----------------------------------------------------------------------------
module tb_io_port_bank;

   localparam int W  = 16;
   localparam int NP = 4;
   localparam int D  = 4;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            IOE, IOR, IOW;
   logic [SW-1:0]   PORT_SEL;
   logic [W-1:0]    Result;
   logic [NP*W-1:0] PORTIN;
   logic [NP-1:0]   PORTIN_VALID;
   logic [NP-1:0]   PORTIN_FULL;
   logic [NP*W-1:0] PORTOUT;
   logic [NP-1:0]   PORTOUT_STB;
   logic [W-1:0]    IN;
   logic            IN_VALID;
`ifdef IO_IRQ_EN
   logic            IRQ;
`endif

   io_port_bank #(.WIDTH(W), .NPORTS(NP), .DEPTH(D), .SELW(SW)) dut (
      .clk          (clk),
      .reset        (reset),
      .IOE          (IOE),
      .IOR          (IOR),
      .IOW          (IOW),
      .PORT_SEL     (PORT_SEL),
      .Result       (Result),
      .PORTIN       (PORTIN),
      .PORTIN_VALID (PORTIN_VALID),
      .PORTIN_FULL  (PORTIN_FULL),
      .PORTOUT      (PORTOUT),
      .PORTOUT_STB  (PORTOUT_STB),
      .IN           (IN),
      .IN_VALID     (IN_VALID)
`ifdef IO_IRQ_EN
      ,
      .IRQ          (IRQ)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NP-1:0]   stb;
      logic [NP*W-1:0] po;
   } wexp_t;

   logic [W-1:0] rq[$];
   wexp_t        wq[$];
   logic [W-1:0] exp_po[NP];
   int           n_checks = 0;
   int           n_pass   = 0;
   bit           mon_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [NP*W-1:0] pack_po();
      logic [NP*W-1:0] v;
      for (int k = 0; k < NP; k++) v[k*W +: W] = exp_po[k];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      IOE = 1'b0; IOR = 1'b0; IOW = 1'b0;
      PORT_SEL = '0; Result = '0;
      PORTIN = '0; PORTIN_VALID = '0;
   endtask

   // One clock of stimulus. pch<0 means no push. Expectations for reads and
   // writes are queued before the edge; an empty read is checked directly.
   task automatic cyc(input int pch, input logic [W-1:0] pd, input int sel,
                      input bit ioe, input bit rd, input bit wr,
                      input logic [W-1:0] res, input bit exp_rv,
                      input logic [W-1:0] exp_rd);
      wexp_t we;
      if (pch >= 0) begin
         PORTIN[pch*W +: W] = pd;
         PORTIN_VALID[pch]  = 1'b1;
      end
      IOE = ioe; IOR = rd; IOW = wr;
      PORT_SEL = SW'(sel); Result = res;
      if (ioe && rd && exp_rv) rq.push_back(exp_rd);
      if (ioe && wr && sel < NP) begin
         exp_po[sel] = res;
         we.stb = NP'(1) << sel;
         we.po  = pack_po();
         wq.push_back(we);
      end
      tick();
      clear_inputs();
      if (ioe && rd && !exp_rv) check("pop_empty", IN_VALID, 0);
   endtask

   task automatic push(input int ch, input logic [W-1:0] d);
      cyc(ch, d, 0, 0, 0, 0, '0, 0, '0);
   endtask

   task automatic pop(input int ch, input bit v, input logic [W-1:0] d);
      cyc(-1, '0, ch, 1, 1, 0, '0, v, d);
   endtask

   // Monitor: every presented output must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (IN_VALID) begin
            if (rq.size() == 0) check("unexpected_in_valid", IN_VALID, 0);
            else check("in_data", IN, rq.pop_front());
         end
         if (PORTOUT_STB != '0) begin
            if (wq.size() == 0) check("unexpected_stb", PORTOUT_STB, 0);
            else begin
               wexp_t e;
               e = wq.pop_front();
               check("portout_stb", PORTOUT_STB, e.stb);
               check("portout", PORTOUT, e.po);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NP; k++) exp_po[k] = '0;
      clear_inputs();

      // Reset / idle
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check("rst_portout", PORTOUT, 0);
      check("rst_stb", PORTOUT_STB, 0);
      check("rst_in", IN, 0);
      check("rst_in_valid", IN_VALID, 0);
      check("rst_full", PORTIN_FULL, 0);
`ifdef IO_IRQ_EN
      check("rst_irq", IRQ, 0);
`endif
      mon_en = 1'b1;
      pop(0, 0, '0);

      // FIFO order and full on channel 1
      push(1, 16'h1111); push(1, 16'h2222); push(1, 16'h3333);
      check("full_before_4th", PORTIN_FULL[1], 0);
      push(1, 16'h4444);
      check("full_after_4th", PORTIN_FULL, 4'b0010);
      push(1, 16'h5555);
      check("full_after_drop", PORTIN_FULL[1], 1);
      pop(1, 1, 16'h1111);
      check("full_release", PORTIN_FULL[1], 0);
      pop(1, 1, 16'h2222); pop(1, 1, 16'h3333); pop(1, 1, 16'h4444);
      pop(1, 0, '0);
      check("in_hold_after_empty", IN, 16'h4444);

      // Full channel: push and pop together -> pop wins, push dropped
      push(1, 16'h0010); push(1, 16'h0011); push(1, 16'h0012); push(1, 16'h0013);
      cyc(1, 16'h0099, 1, 1, 1, 0, '0, 1, 16'h0010);
      check("full_pushpop_full", PORTIN_FULL[1], 0);
      pop(1, 1, 16'h0011); pop(1, 1, 16'h0012); pop(1, 1, 16'h0013);
      pop(1, 0, '0);

      // Wrap-around on channel 2
      for (int i = 0; i < 6; i++) begin
         push(2, W'(16'h2000 + 2*i));
         push(2, W'(16'h2001 + 2*i));
         pop(2, 1, W'(16'h2000 + 2*i));
         pop(2, 1, W'(16'h2001 + 2*i));
      end

      // Empty channel, push and pop together: no bypass
      cyc(2, 16'h5A5A, 2, 1, 1, 0, '0, 0, '0);
      pop(2, 1, 16'h5A5A);
      pop(2, 0, '0);

      // Simultaneous push, pop and write on channel 3
      push(3, 16'hAAAA);
      cyc(3, 16'hBBBB, 3, 1, 1, 1, 16'hC0DE, 1, 16'hAAAA);
      check("simul_full", PORTIN_FULL[3], 0);
      pop(3, 1, 16'hBBBB);
      pop(3, 0, '0);

      // IOE=0 ignores IOR and IOW
      push(0, 16'h0F0F);
      cyc(-1, '0, 0, 0, 1, 1, 16'hFFFF, 0, '0);
      check("ioe0_no_stb", PORTOUT_STB, 0);
      check("ioe0_portout", PORTOUT, pack_po());
      check("ioe0_no_read", IN_VALID, 0);
      pop(0, 1, 16'h0F0F);

      // Out-of-range PORT_SEL
      cyc(-1, '0, 0, 1, 0, 1, 16'h1234, 0, '0);
      cyc(-1, '0, 5, 1, 1, 1, 16'hFFFF, 0, '0);
      check("oor_no_stb", PORTOUT_STB, 0);
      check("oor_portout", PORTOUT, pack_po());
      check("oor_in_hold", IN, 16'h0F0F);

      // Reset mid-operation, with a write requested in the reset cycle
      push(0, 16'h0101); push(0, 16'h0202);
      reset = 1'b1;
      IOE = 1'b1; IOW = 1'b1; PORT_SEL = 3'd1; Result = 16'hDEAD;
      tick();
      clear_inputs();
      reset = 1'b0;
      for (int k = 0; k < NP; k++) exp_po[k] = '0;
      check("midrst_portout", PORTOUT, 0);
      check("midrst_stb", PORTOUT_STB, 0);
      check("midrst_in", IN, 0);
      check("midrst_full", PORTIN_FULL, 0);
      pop(0, 0, '0);
      push(0, 16'h7777);
      pop(0, 1, 16'h7777);

`ifdef IO_IRQ_EN
      tick();
      check("irq_idle", IRQ, 0);
      push(0, 16'h4242);
      check("irq_set", IRQ, 1);
      pop(0, 1, 16'h4242);
      check("irq_clear", IRQ, 0);
`endif

      tick(); tick();
      check("read_queue_drained", rq.size(), 0);
      check("write_queue_drained", wq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
